// File: rtl/goal_event_ctrl.sv
// goal_event_ctrl
// Owns the score and the goal banner enable. Once per frame the ball
// position is tested against both goal mouths; a hit credits the scorer,
// starts a blinking celebration, then either hands the ball back to the
// ball mover (reset handshake) or latches game-over at the winning score.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_PLAY     | normal play, goal detection on armed frames
// ST_CELEB    | goal celebration, banner blinks for SHOW_FRAMES frames
// ST_RESET_BA | ball_reset_req held high until ball mover acks
// ST_OVER     | a side reached WIN_SCORE, banner steady, scores frozen

module goal_event_ctrl #(
  parameter int LEFT_GOAL_X_MAX  = 8,
  parameter int RIGHT_GOAL_X_MIN = 616,
  parameter int GOAL_Y_MIN       = 190,
  parameter int GOAL_Y_MAX       = 290,
  parameter int BALL_SIZE        = 16,
  parameter int SHOW_FRAMES      = 120,
  parameter int BLINK_FRAMES     = 15,
  parameter int WIN_SCORE        = 5
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame_i,
  input  logic [10:0] ball_x_i,
  input  logic [10:0] ball_y_i,
  input  logic        game_active_i,
  input  logic        new_game_i,
  input  logic        ball_reset_ack_i,
  output logic        goal_ena_o,
  output logic        ball_reset_req_o,
  output logic [3:0]  score_left_o,
  output logic [3:0]  score_right_o,
  output logic        last_scorer_o,
  output logic        game_over_o
);

  localparam int FRAME_W = (SHOW_FRAMES > 1) ? $clog2(SHOW_FRAMES) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] ST_PLAY     = 2'd0;
  localparam logic [1:0] ST_CELEB    = 2'd1;
  localparam logic [1:0] ST_RESET_BA = 2'd2;
  localparam logic [1:0] ST_OVER     = 2'd3;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SHOW_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [3:0]         WIN_Q      = 4'(WIN_SCORE);

  logic [1:0]         state_q, state_d;
  logic [3:0]         score_left_q, score_left_d;
  logic [3:0]         score_right_q, score_right_d;
  logic               last_scorer_q, last_scorer_d;
  logic               arm_q, arm_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               goal_ena_q, goal_ena_d;
  logic               req_q, req_d;
  logic               game_over_q, game_over_d;

  logic        in_mouth_y;
  logic        hit_left;
  logic        hit_right;
  logic [11:0] ball_bottom;
  logic        win_reached;
  logic        detect_en;

  // Goal-mouth geometry; the bottom edge uses a 12-bit sum so a ball near
  // the top of the 11-bit range cannot wrap back into the mouth.
  always_comb begin
    ball_bottom = {1'b0, ball_y_i} + 12'(BALL_SIZE);
    in_mouth_y  = (ball_y_i >= 11'(GOAL_Y_MIN)) && (ball_bottom <= 12'(GOAL_Y_MAX));
    hit_left    = in_mouth_y && (ball_x_i <= 11'(LEFT_GOAL_X_MAX));
    hit_right   = in_mouth_y && (ball_x_i >= 11'(RIGHT_GOAL_X_MIN));
    detect_en   = startOfFrame_i && game_active_i && arm_q;
    win_reached = last_scorer_q ? (score_right_q == WIN_Q) : (score_left_q == WIN_Q);
  end

  // Next-state logic for the sequencing FSM, counters and score registers.
  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    last_scorer_d = last_scorer_q;
    arm_d         = arm_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    phase_d       = phase_q;
    goal_ena_d    = goal_ena_q;
    req_d         = req_q;
    game_over_d   = game_over_q;

    if (new_game_i) begin
      state_d       = ST_PLAY;
      score_left_d  = 4'd0;
      score_right_d = 4'd0;
      game_over_d   = 1'b0;
      goal_ena_d    = 1'b0;
      req_d         = 1'b0;
      arm_d         = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          goal_ena_d = 1'b0;
          req_d      = 1'b0;
          if (startOfFrame_i && !arm_q) begin
            // first frame after re-entry only re-arms; the ball may not
            // have moved yet
            arm_d = 1'b1;
          end else if (detect_en && (hit_left || hit_right)) begin
            // left mouth takes precedence if both ever match
            if (hit_left) begin
              if (score_right_q < WIN_Q) score_right_d = score_right_q + 4'd1;
              last_scorer_d = 1'b1;
            end else begin
              if (score_left_q < WIN_Q) score_left_d = score_left_q + 4'd1;
              last_scorer_d = 1'b0;
            end
            state_d     = ST_CELEB;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
            goal_ena_d  = 1'b1;
          end
        end

        ST_CELEB: begin
          if (startOfFrame_i) begin
            if (frame_cnt_q == FRAME_LAST) begin
              if (win_reached) begin
                state_d     = ST_OVER;
                goal_ena_d  = 1'b1;
                game_over_d = 1'b1;
              end else begin
                state_d    = ST_RESET_BA;
                goal_ena_d = 1'b0;
                req_d      = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
                goal_ena_d  = ~phase_q;
              end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
              end
            end
          end
        end

        ST_RESET_BA: begin
          goal_ena_d = 1'b0;
          if (ball_reset_ack_i) begin
            req_d   = 1'b0;
            arm_d   = 1'b0;
            state_d = ST_PLAY;
          end
        end

        default: begin
          goal_ena_d  = 1'b1;
          game_over_d = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= ST_PLAY;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      last_scorer_q <= 1'b0;
      arm_q         <= 1'b1;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      goal_ena_q    <= 1'b0;
      req_q         <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      last_scorer_q <= last_scorer_d;
      arm_q         <= arm_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      goal_ena_q    <= goal_ena_d;
      req_q         <= req_d;
      game_over_q   <= game_over_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    goal_ena_o       = goal_ena_q;
    ball_reset_req_o = req_q;
    score_left_o     = score_left_q;
    score_right_o    = score_right_q;
    last_scorer_o    = last_scorer_q;
    game_over_o      = game_over_q;
  end

endmodule
